// File: rtl/i2c_slave_regfile_if.sv
// I2C pin bundle shared by the slave register file and its bus partner.
// The slave pulls SDA low with sda_oe; the pad resolves the open-drain line.
interface i2c_if;
    logic scl_in;
    logic sda_in;
    logic sda_oe;

    modport master (output scl_in, output sda_in, input sda_oe);
    modport slave  (input scl_in, input sda_in, output sda_oe);
endinterface

// File: rtl/i2c_slave_regfile.sv
// Clocked I2C slave with a byte register file, auto-incrementing pointer,
// burst read/write, repeated START, host read port and write-notify strobe.
module i2c_slave_regfile #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         DEPTH      = 16,
    parameter int         ADDR_W     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    i2c_if.slave              bus,
    input  logic [ADDR_W-1:0] host_raddr,
    output logic [7:0]        host_rdata,
    output logic              wr_pulse,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          scl_pipe_q, scl_pipe_d;
    logic [2:0]          sda_pipe_q, sda_pipe_d;
    logic [3:0]          bit_cnt_q, bit_cnt_d;
    logic [7:0]          shift_q, shift_d;
    logic                rw_q, rw_d;
    logic                ack_q, ack_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic                sda_oe_q, sda_oe_d;
    logic                busy_q, busy_d;
    logic                wr_pulse_q, wr_pulse_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [7:0]          wr_data_q, wr_data_d;
    logic [7:0]          mem_q [DEPTH];
    logic [7:0]          mem_d [DEPTH];

    logic                scl_rise, scl_fall, start_det, stop_det, sda_s;
    logic [ADDR_W-1:0]   ptr_inc;

    // [0] and [1] form the synchroniser, [2] is the previous synced value for edge detection
    assign sda_s     = sda_pipe_q[1];
    assign scl_rise  =  scl_pipe_q[1] & ~scl_pipe_q[2];
    assign scl_fall  = ~scl_pipe_q[1] &  scl_pipe_q[2];
    assign start_det =  scl_pipe_q[1] & scl_pipe_q[2] &  sda_pipe_q[2] & ~sda_pipe_q[1];
    assign stop_det  =  scl_pipe_q[1] & scl_pipe_q[2] & ~sda_pipe_q[2] &  sda_pipe_q[1];
    assign ptr_inc   = ptr_q + ADDR_W'(1);

    always_comb begin
        scl_pipe_d = {scl_pipe_q[1:0], bus.scl_in};
        sda_pipe_d = {sda_pipe_q[1:0], bus.sda_in};
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        rw_d       = rw_q;
        ack_d      = ack_q;
        ptr_d      = ptr_q;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        wr_pulse_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        mem_d      = mem_q;

        if (stop_det) begin
            state_d   = IDLE;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
            bit_cnt_d = 4'd0;
        end else if (start_det) begin
            state_d   = ADDR;
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
        end else begin
            case (state_q)
                ADDR, PTR, WDATA: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        bit_cnt_d = 4'd0;
                        case (state_q)
                            ADDR: begin
                                if (shift_q[7:1] == SLAVE_ADDR) begin
                                    sda_oe_d = 1'b1;
                                    busy_d   = 1'b1;
                                    rw_d     = shift_q[0];
                                    state_d  = ADDR_ACK;
                                end else begin
                                    busy_d  = 1'b0;
                                    state_d = WAIT;
                                end
                            end
                            PTR: begin
                                ptr_d    = shift_q[ADDR_W-1:0];
                                sda_oe_d = 1'b1;
                                state_d  = PTR_ACK;
                            end
                            default: begin
                                mem_d[ptr_q] = shift_q;
                                wr_pulse_d   = 1'b1;
                                wr_addr_d    = ptr_q;
                                wr_data_d    = shift_q;
                                ptr_d        = ptr_inc;
                                sda_oe_d     = 1'b1;
                                state_d      = WDATA_ACK;
                            end
                        endcase
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_d = 4'd0;
                        if (rw_q) begin
                            shift_d  = mem_q[ptr_q];
                            sda_oe_d = ~mem_q[ptr_q][7];
                            state_d  = RDATA;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = PTR;
                        end
                    end
                end
                PTR_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        state_d  = WDATA;
                    end
                end
                RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d  = 1'b0;
                            ack_d     = 1'b0;
                            bit_cnt_d = 4'd0;
                            state_d   = RDATA_ACK;
                        end else begin
                            shift_d  = {shift_q[6:0], 1'b0};
                            sda_oe_d = ~shift_q[6];
                        end
                    end
                end
                RDATA_ACK: begin
                    // Next byte is fetched on the ACK but only driven once SCL is low again
                    if (scl_rise) begin
                        if (sda_s) begin
                            state_d  = WAIT;
                            busy_d   = 1'b0;
                            sda_oe_d = 1'b0;
                        end else begin
                            ptr_d   = ptr_inc;
                            shift_d = mem_q[ptr_inc];
                            ack_d   = 1'b1;
                        end
                    end else if (scl_fall && ack_q) begin
                        sda_oe_d = ~shift_q[7];
                        ack_d    = 1'b0;
                        state_d  = RDATA;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            scl_pipe_q <= 3'b111;
            sda_pipe_q <= 3'b111;
            bit_cnt_q  <= 4'd0;
            shift_q    <= 8'h00;
            rw_q       <= 1'b0;
            ack_q      <= 1'b0;
            ptr_q      <= '0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            wr_pulse_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= 8'h00;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
        end else begin
            state_q    <= state_d;
            scl_pipe_q <= scl_pipe_d;
            sda_pipe_q <= sda_pipe_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            rw_q       <= rw_d;
            ack_q      <= ack_d;
            ptr_q      <= ptr_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            wr_pulse_q <= wr_pulse_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
        end
    end

    assign bus.sda_oe = sda_oe_q;
    assign busy       = busy_q;
    assign wr_pulse   = wr_pulse_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign host_rdata = mem_q[host_raddr];

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench for i2c_slave_regfile: bit-banged I2C master, register model
// and scoreboard queues for written and read-back bytes.
`timescale 1ns/1ps
module tb_i2c_slave_regfile;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int T     = 8;

    logic clk = 1'b0;
    logic rst;
    logic scl_m, sda_m;
    logic [AW-1:0] host_raddr;
    logic [7:0]    host_rdata;
    logic          wr_pulse;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          busy;

    always #5 clk = ~clk;

    i2c_if bus();
    assign bus.scl_in = scl_m;
    assign bus.sda_in = sda_m & ~bus.sda_oe;

    i2c_slave_regfile #(.SLAVE_ADDR(7'h50), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .host_raddr (host_raddr),
        .host_rdata (host_rdata),
        .wr_pulse   (wr_pulse),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy)
    );

    int checks   = 0;
    int failures = 0;
    int obs_idx  = 0;
    int oe_viol  = 0;
    int busy_viol = 0;
    logic quiet_watch;
    logic [7:0]    model_mem [DEPTH];
    logic [AW-1:0] model_ptr;
    logic [31:0]   exp_wr [$];
    logic [31:0]   obs_wr [$];
    logic [7:0]    exp_rd [$];

    always @(negedge clk) begin
        if (wr_pulse === 1'b1) obs_wr.push_back({20'd0, wr_addr, wr_data});
        if (quiet_watch === 1'b1 && bus.sda_oe !== 1'b0) oe_viol <= oe_viol + 1;
        if (quiet_watch === 1'b1 && busy !== 1'b0) busy_viol <= busy_viol + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        wait_clk(T); sda_m = b;
        wait_clk(T); scl_m = 1'b1;
        wait_clk(2*T); scl_m = 1'b0;
    endtask

    task automatic recv_bit(output logic b);
        wait_clk(T); sda_m = 1'b1;
        wait_clk(T); scl_m = 1'b1;
        wait_clk(T); b = bus.sda_in;
        wait_clk(T); scl_m = 1'b0;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_clk(T);
        scl_m = 1'b1; wait_clk(T);
        sda_m = 1'b0; wait_clk(T);
        scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        wait_clk(T); sda_m = 1'b0;
        wait_clk(T); scl_m = 1'b1;
        wait_clk(T); sda_m = 1'b1;
        wait_clk(T);
    endtask

    // Send a byte and check the slave's ACK bit (0 = ACK, 1 = no ACK)
    task automatic put_byte(input string tag, input logic [7:0] b, input logic exp_ack);
        logic a;
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        recv_bit(a);
        check(tag, 32'(a), 32'(exp_ack));
    endtask

    task automatic data_wr(input string tag, input logic [7:0] d);
        exp_wr.push_back({20'd0, model_ptr, d});
        model_mem[model_ptr] = d;
        model_ptr = model_ptr + 4'd1;
        put_byte(tag, d, 1'b0);
    endtask

    task automatic get_byte(input string tag, input logic give_ack);
        logic [7:0] b;
        logic [7:0] e;
        exp_rd.push_back(model_mem[model_ptr]);
        for (int i = 7; i >= 0; i--) recv_bit(b[i]);
        send_bit(give_ack ? 1'b0 : 1'b1);
        e = exp_rd.pop_front();
        check(tag, 32'(b), 32'(e));
        if (give_ack) model_ptr = model_ptr + 4'd1;
    endtask

    task automatic drain_writes(input string tag);
        logic [31:0] e;
        wait_clk(4);
        check({tag, "_wr_count"}, 32'(obs_wr.size() - obs_idx), 32'(exp_wr.size()));
        while (exp_wr.size() > 0 && obs_idx < obs_wr.size()) begin
            e = exp_wr.pop_front();
            check({tag, "_wr"}, obs_wr[obs_idx], e);
            obs_idx++;
        end
        exp_wr.delete();
        obs_idx = obs_wr.size();
    endtask

    task automatic host_chk(input string tag, input logic [AW-1:0] a);
        host_raddr = a;
        #1;
        check(tag, 32'(host_rdata), 32'(model_mem[a]));
    endtask

    initial begin
        int oe0, busy0;
        rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; host_raddr = '0; quiet_watch = 1'b0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
        model_ptr = '0;
        wait_clk(5);
        check("rst_sda_oe", 32'(bus.sda_oe), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wr_pulse", 32'(wr_pulse), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        host_chk("rst_mem0", 4'h0);
        rst = 1'b0;
        wait_clk(10);

        // 1: burst write wrapping the pointer E -> F -> 0
        i2c_start();
        put_byte("t1_addr", 8'hA0, 1'b0);
        check("t1_busy", 32'(busy), 32'd1);
        put_byte("t1_ptr", 8'h0E, 1'b0);
        model_ptr = 4'hE;
        data_wr("t1_d0", 8'h11);
        data_wr("t1_d1", 8'h22);
        data_wr("t1_d2", 8'h33);
        i2c_stop();
        check("t1_busy_after_stop", 32'(busy), 32'd0);
        drain_writes("t1");
        host_chk("t1_memE", 4'hE);
        host_chk("t1_memF", 4'hF);
        host_chk("t1_mem0", 4'h0);

        // preload registers 2..4 for the read test
        i2c_start();
        put_byte("pre_addr", 8'hA0, 1'b0);
        put_byte("pre_ptr", 8'h02, 1'b0);
        model_ptr = 4'h2;
        data_wr("pre_d0", 8'hC3);
        data_wr("pre_d1", 8'h5A);
        data_wr("pre_d2", 8'h96);
        i2c_stop();
        drain_writes("pre");

        // 2: set pointer, repeated START, burst read ACK,ACK,NACK
        i2c_start();
        put_byte("t2_addr", 8'hA0, 1'b0);
        put_byte("t2_ptr", 8'h02, 1'b0);
        model_ptr = 4'h2;
        i2c_start();
        put_byte("t2_raddr", 8'hA1, 1'b0);
        get_byte("t2_rd0", 1'b1);
        get_byte("t2_rd1", 1'b1);
        get_byte("t2_rd2", 1'b0);
        oe0 = oe_viol;
        quiet_watch = 1'b1;
        wait_clk(4*T);
        check("t2_busy_after_nack", 32'(busy), 32'd0);
        i2c_stop();
        quiet_watch = 1'b0;
        wait_clk(2);
        check("t2_oe_after_nack", 32'(oe_viol - oe0), 32'd0);
        drain_writes("t2");

        // 3: address mismatch followed by data bytes
        oe0 = oe_viol; busy0 = busy_viol;
        quiet_watch = 1'b1;
        i2c_start();
        put_byte("t3_addr_nack", 8'hB0, 1'b1);
        for (int k = 0; k < 4; k++) put_byte("t3_data_nack", 8'(8'h21 * (k + 1)), 1'b1);
        i2c_stop();
        quiet_watch = 1'b0;
        wait_clk(2);
        check("t3_sda_oe_quiet", 32'(oe_viol - oe0), 32'd0);
        check("t3_busy_quiet", 32'(busy_viol - busy0), 32'd0);
        drain_writes("t3");

        // 4: STOP after five bits of a data byte
        i2c_start();
        put_byte("t4_addr", 8'hA0, 1'b0);
        put_byte("t4_ptr", 8'h07, 1'b0);
        model_ptr = 4'h7;
        for (int k = 0; k < 5; k++) send_bit(1'b1);
        i2c_stop();
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_sda_oe", 32'(bus.sda_oe), 32'd0);
        drain_writes("t4");
        host_chk("t4_mem7", 4'h7);
        put_byte("t4_idle_nack", 8'hA0, 1'b1);
        i2c_stop();
        drain_writes("t4_idle");

        // 5: asynchronous reset while the slave drives a 0 data bit
        i2c_start();
        put_byte("t5_addr", 8'hA0, 1'b0);
        put_byte("t5_ptr", 8'h03, 1'b0);
        i2c_start();
        put_byte("t5_raddr", 8'hA1, 1'b0);
        wait_clk(4);
        check("t5_driving_zero", 32'(bus.sda_oe), 32'd1);
        rst = 1'b1;
        #1;
        check("t5_async_release", 32'(bus.sda_oe), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        scl_m = 1'b1; wait_clk(T);
        sda_m = 1'b1; wait_clk(T);
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
        model_ptr = '0;
        exp_rd.delete();
        for (int i = 0; i < DEPTH; i++) host_chk("t5_mem_cleared", 4'(i));
        rst = 1'b0;
        wait_clk(10);

        // 6: pointer byte upper bits ignored
        i2c_start();
        put_byte("t6_addr", 8'hA0, 1'b0);
        put_byte("t6_ptr", 8'h35, 1'b0);
        model_ptr = 4'h5;
        data_wr("t6_d0", 8'hA7);
        i2c_stop();
        drain_writes("t6");
        host_chk("t6_mem5", 4'h5);
        i2c_start();
        put_byte("t6_addr2", 8'hA0, 1'b0);
        put_byte("t6_ptr2", 8'h35, 1'b0);
        model_ptr = 4'h5;
        i2c_start();
        put_byte("t6_raddr", 8'hA1, 1'b0);
        get_byte("t6_rd", 1'b0);
        i2c_stop();
        drain_writes("t6_rd");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
